// File: rtl/multiply_tokens_if.sv
// rtl/multiply_tokens_if.sv - token lane bundle between token source and multiplier
interface multiply_tokens_if #(
  parameter int CHANNELS = 1,
  parameter int FACTOR_W = 4
);
  logic [CHANNELS-1:0] a;
  logic [FACTOR_W-1:0] factor;
  logic [CHANNELS-1:0] b;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] overflow;
  logic                overflow_any;

  modport master (
    output a, factor,
    input  b, busy, overflow, overflow_any
  );

  modport slave (
    input  a, factor,
    output b, busy, overflow, overflow_any
  );
endinterface

// File: rtl/multiply_tokens.sv
// rtl/multiply_tokens.sv - per-lane serial token multiplier with backlog and sticky overflow
module multiply_tokens #(
  parameter int CHANNELS    = 1,
  parameter int FACTOR_W    = 4,
  parameter int MAX_PENDING = 200,
  parameter int REG_OUT     = 0
) (
  input  logic               clk,
  input  logic               rst,
  multiply_tokens_if.slave   tok
);
  localparam int CNT_W = $clog2(MAX_PENDING + (1 << FACTOR_W) + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CNT_W-1:0]    nxt   [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;
  logic [CHANNELS-1:0] raw_b;
  logic [CHANNELS-1:0] busy_w;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      raw_b[c] = 1'b0;
      nxt[c]   = '0;
      cnt_d[c] = cnt_q[c];
      ovf_d[c] = ovf_q[c];
      if (!ovf_q[c]) begin
        raw_b[c] = (tok.a[c] && (tok.factor != '0)) || (cnt_q[c] != '0);
        // raw_b is 1 whenever cnt is nonzero or tokens arrive, so this cannot wrap
        nxt[c] = cnt_q[c] + (tok.a[c] ? CNT_W'(tok.factor) : '0) - CNT_W'(raw_b[c]);
        if (nxt[c] > LIMIT) begin
          ovf_d[c] = 1'b1;
          cnt_d[c] = '0;
        end else begin
          cnt_d[c] = nxt[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      busy_w[c] = (cnt_q[c] != '0);
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [CHANNELS-1:0] b_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          b_q <= '0;
        end else begin
          b_q <= raw_b;
        end
      end
      assign tok.b = b_q;
    end else begin : g_comb_out
      // Reset also blanks the zero-latency path so nothing leaks out while rst is low
      assign tok.b = rst ? raw_b : '0;
    end
  endgenerate

  assign tok.busy         = busy_w;
  assign tok.overflow     = ovf_q;
  assign tok.overflow_any = |ovf_q;
endmodule

// File: tb/tb_multiply_tokens.sv
// tb/tb_multiply_tokens.sv - randomized and directed check of multiply_tokens against a backlog model
module tb_multiply_tokens;
  localparam int CH = 4;
  localparam int FW = 4;
  localparam int MAXP = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CH-1:0] a_drv = '0;
  logic [FW-1:0] f_drv = 4'd2;

  int total = 0;
  int bad = 0;

  multiply_tokens_if #(.CHANNELS(CH), .FACTOR_W(FW)) if0 ();
  multiply_tokens_if #(.CHANNELS(CH), .FACTOR_W(FW)) if1 ();

  assign if0.a = a_drv;
  assign if0.factor = f_drv;
  assign if1.a = a_drv;
  assign if1.factor = f_drv;

  multiply_tokens #(.CHANNELS(CH), .FACTOR_W(FW), .MAX_PENDING(MAXP), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .tok(if0.slave)
  );
  multiply_tokens #(.CHANNELS(CH), .FACTOR_W(FW), .MAX_PENDING(MAXP), .REG_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .tok(if1.slave)
  );

  always #5 clk = ~clk;

  // Model: each lane owes an integer number of output tokens
  int      pend [CH];
  bit      movf [CH];
  bit      regb [CH];
  bit      model_ok = 1'b0;

  function automatic bit mout(input int c);
    return !movf[c] && ((a_drv[c] && (f_drv != 0)) || (pend[c] > 0));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        pend[c] = 0;
        movf[c] = 1'b0;
        regb[c] = 1'b0;
      end
      model_ok = 1'b1;
    end else if (model_ok) begin
      for (int c = 0; c < CH; c++) begin
        bit o;
        o = mout(c);
        regb[c] = o;
        if (!movf[c]) begin
          pend[c] = pend[c] + (a_drv[c] ? int'(f_drv) : 0) - (o ? 1 : 0);
          if (pend[c] > MAXP) begin
            movf[c] = 1'b1;
            pend[c] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic [CH-1:0] eb0, eb1, ebusy, eovf;
      for (int c = 0; c < CH; c++) begin
        eb0[c]   = rst ? mout(c) : 1'b0;
        eb1[c]   = regb[c];
        ebusy[c] = (pend[c] != 0);
        eovf[c]  = movf[c];
      end
      check("cyc_b_comb", 32'(if0.b), 32'(eb0));
      check("cyc_b_reg", 32'(if1.b), 32'(eb1));
      check("cyc_busy0", 32'(if0.busy), 32'(ebusy));
      check("cyc_busy1", 32'(if1.busy), 32'(ebusy));
      check("cyc_ovf0", 32'(if0.overflow), 32'(eovf));
      check("cyc_ovf1", 32'(if1.overflow), 32'(eovf));
      check("cyc_any0", 32'(if0.overflow_any), 32'(|eovf));
      check("cyc_any1", 32'(if1.overflow_any), 32'(|eovf));
    end
  end

  logic [CH-1:0] cap_b0, cap_b1, cap_busy, cap_ovf;
  logic          cap_any;

  task automatic step(input logic [CH-1:0] av, input logic [FW-1:0] fv);
    a_drv = av;
    f_drv = fv;
    @(negedge clk);
    cap_b0 = if0.b;
    cap_b1 = if1.b;
    cap_busy = if0.busy;
    cap_ovf = if0.overflow;
    cap_any = if0.overflow_any;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step('1, 4'd2);
    check("reset_forces_b", 32'(cap_b0), 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    logic [25:0] cv;
    logic [25:0] cres;
    logic [6:0]  sb, sbusy;
    logic [3:0]  s4;
    logic [4:0]  s5a, s5b;
    logic [1:0]  s2;
    int          ones;

    rst = 1'b0;
    step('0, 4'd2);
    do_reset();
    step('0, 4'd2);
    check("reset_b", 32'(cap_b0), 32'h0);
    check("reset_busy", 32'(cap_busy), 32'h0);
    check("reset_ovf", 32'(cap_ovf), 32'h0);
    check("reset_b_reg", 32'(cap_b1), 32'h0);

    cv = 26'b10010011000110100001100100;
    cres = '0;
    for (int i = 25; i >= 0; i--) begin
      step({CH{cv[i]}}, 4'd2);
      cres = {cres[24:0], cap_b0[0]};
    end
    check("compat_b", 32'(cres), 32'(26'b11011011110111111001111110));
    step('0, 4'd2);
    check("compat_ovf", 32'(cap_ovf), 32'h0);

    sb = '0;
    sbusy = '0;
    for (int i = 6; i >= 0; i--) begin
      step((i == 6) ? 4'b0001 : 4'b0000, 4'd3);
      sb = {sb[5:0], cap_b0[0]};
      sbusy = {sbusy[5:0], cap_busy[0]};
    end
    check("f3_b", 32'(sb), 32'(7'b1110000));
    check("f3_busy", 32'(sbusy), 32'(7'b0110000));

    s4 = '0;
    for (int i = 0; i < 4; i++) begin
      step('1, 4'd0);
      s4 = {s4[2:0], cap_b0[0]};
    end
    check("f0_b", 32'(s4), 32'h0);

    cv = '0;
    cv[3:0] = 4'b1011;
    s4 = '0;
    for (int i = 3; i >= 0; i--) begin
      step({CH{cv[i]}}, 4'd1);
      s4 = {s4[2:0], cap_b0[0]};
    end
    check("f1_b", 32'(s4), 32'(4'b1011));

    do_reset();
    for (int i = 0; i < 200; i++) step('1, 4'd2);
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      step('0, 4'd2);
      if (i == 0) begin
        check("ovf200_none", 32'(cap_ovf), 32'h0);
        check("ovf200_busy", 32'(cap_busy), 32'hF);
      end
      ones += int'(cap_b0[0]);
    end
    check("ovf200_tail", 32'(ones), 32'd200);
    step('0, 4'd2);
    check("ovf200_idle", 32'(cap_b0), 32'h0);

    for (int i = 0; i < 201; i++) step('1, 4'd2);
    step('1, 4'd2);
    check("ovf201_flag", 32'(cap_ovf), 32'hF);
    check("ovf201_any", 32'(cap_any), 32'h1);
    check("ovf201_b", 32'(cap_b0), 32'h0);
    for (int i = 0; i < 5; i++) step('1, 4'd2);
    check("ovf201_sticky", 32'(cap_ovf), 32'hF);

    do_reset();
    step(4'b1111, 4'd15);
    ones = 1;
    for (int i = 0; i < 14; i++) begin
      step(4'b0100, 4'd15);
      ones += int'(cap_b0[0]);
    end
    step(4'b0100, 4'd15);
    check("mc_ovf", 32'(cap_ovf), 32'(4'b0100));
    check("mc_any", 32'(cap_any), 32'h1);
    check("mc_ch0_run", 32'(ones), 32'd15);

    step(4'b0001, 4'd6);
    rst = 1'b0;
    step('0, 4'd6);
    rst = 1'b1;
    step('0, 4'd2);
    check("rst_mid_b", 32'(cap_b0), 32'h0);
    check("rst_mid_b_reg", 32'(cap_b1), 32'h0);
    check("rst_mid_busy", 32'(cap_busy), 32'h0);
    check("rst_mid_ovf", 32'(cap_ovf), 32'h0);
    s2 = '0;
    step(4'b0001, 4'd2);
    s2 = {s2[0], cap_b0[0]};
    step('0, 4'd2);
    s2 = {s2[0], cap_b0[0]};
    check("rst_mid_tok", 32'(s2), 32'(2'b11));

    step('0, 4'd2);
    s5a = '0;
    s5b = '0;
    cv = '0;
    cv[4:0] = 5'b10010;
    for (int i = 4; i >= 0; i--) begin
      step({CH{cv[i]}}, 4'd2);
      s5a = {s5a[3:0], cap_b0[0]};
      s5b = {s5b[3:0], cap_b1[0]};
    end
    check("regout_comb", 32'(s5a), 32'(5'b11011));
    check("regout_reg", 32'(s5b), 32'(5'b01101));

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 79) != 0);
      step(CH'($urandom), ($urandom_range(0, 3) == 0) ? FW'($urandom) : FW'($urandom_range(0, 2)));
    end
    rst = 1'b1;
    step('0, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multiply_tokens.md
# multiply_tokens

Parametrised serial token multiplier, the successor to the fixed two-times doubler. Each incoming '1' on a channel becomes a run-time-selectable number of '1's on that channel's output, with a per-channel backlog counter. It supports independent lanes, a programmable backlog limit, a sticky per-channel overflow and an optional registered output stage. It sits in the serial token datapath between a token source and downstream serial consumers.

## Interface
- CHANNELS, 1: number of independent token lanes.
- FACTOR_W, 4: width of `factor`; max repeat factor 2^FACTOR_W-1.
- MAX_PENDING, 200: largest legal backlog per channel.
- REG_OUT, 0: 0 = `b` combinational from `a`; 1 = `b` registered (+1 cycle).
- CNT_W (localparam) = $clog2(MAX_PENDING + 2^FACTOR_W + 1).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- a  in  CHANNELS  serial token input per channel.
- factor  in  FACTOR_W  repeat factor; shared by all channels; sampled every cycle.
- b  out  CHANNELS  serial multiplied token output per channel.
- busy  out  CHANNELS  1 when the channel backlog is nonzero.
- overflow  out  CHANNELS  sticky per-channel overflow.
- overflow_any  out  1  OR of `overflow`.

## Operation
- Each channel c has a backlog counter cnt[c] (CNT_W bits) and a sticky flag ovf[c].
- Raw output (channel not overflowed): raw_b = (a[c] & (factor != 0)) | (cnt[c] != 0).
- Next backlog: nxt = cnt + (a[c] ? factor : 0) - raw_b. This is computed at CNT_W width and cannot underflow.
- Normal case, nxt <= MAX_PENDING: cnt <= nxt.
- Overflow case, nxt > MAX_PENDING: ovf[c] <= 1 and cnt[c] <= 0. raw_b in the offending cycle is still the normal value.
- Overflowed channel (ovf=1):
  - raw_b = 0, cnt held at 0, busy = 0.
  - `a` and `factor` are ignored.
  - Only reset clears it.
- factor = 1: b equals a. factor = 0: input tokens are dropped, and any existing backlog still drains at 1 per cycle.
- A change of `factor` affects only tokens arriving in that cycle. Backlog already accumulated is unaffected.
- With factor = 2 and the default MAX_PENDING, behaviour is identical to the legacy doubler:
  - a run of k ones leaves cnt = k;
  - 200 consecutive ones is legal; the 201st sets overflow.
- Channels are fully independent. Simultaneous overflow on several channels sets each flag individually.

## Timing
- REG_OUT=0: b[c] = raw_b in the same cycle as `a` (zero latency, combinational from `a`, `factor`, cnt).
- REG_OUT=1: b[c] is raw_b delayed one cycle through a flop.
- busy reflects registered cnt: it rises the cycle after the token that creates backlog.
- overflow rises the cycle after the offending token. overflow_any rises in that same cycle.
- Reset (rst=0 at a clock edge):
  - cnt=0, ovf=0, output flop=0;
  - after that edge b=0, busy=0, overflow=0, overflow_any=0;
  - with REG_OUT=0, b is also forced 0 combinationally while rst=0.
- Reset mid-run discards the backlog. The first cycle after release behaves as from idle.
- Boundaries:
  - nxt == MAX_PENDING is legal;
  - nxt == MAX_PENDING+1 overflows;
  - max factor with cnt == MAX_PENDING and a=1 still fits in CNT_W.

## Test plan
- Compatibility, factor=2, CHANNELS=1, REG_OUT=0: a=10010011000110100001100100 -> b=11011011110111111001111110, overflow stays 0.
- Factor sweep:
  - factor=3, single token a=1000000 -> b=1110000, busy high for 2 cycles;
  - factor=0, a=1111 -> b=0000;
  - factor=1 -> b==a.
- Overflow boundary, factor=2:
  - 200 consecutive ones -> no overflow, then 200 trailing ones on b;
  - 201 ones -> overflow and overflow_any rise the cycle after the 201st, after which b=0 despite a=1, and it stays set until rst=0.
- Multi-channel (CHANNELS=4): overflow channel 2 only -> overflow=0100; channels 0, 1 and 3 keep multiplying correctly in the same cycles.
- REG_OUT=1, factor=2: a=1001 -> b=01101, exactly 1 cycle behind the REG_OUT=0 result.
- Reset mid-operation: assert rst=0 for 1 cycle with cnt=5 and overflow set -> next cycle b=0, busy=0, overflow=0. A subsequent single token with factor=2 -> b=11.
